instr_encoder: RTL and testbench

// Inverse of the control unit: packs symbolic requests into 32-bit RV32I instruction words.

---
 rtl/instr_encoder.sv | 172 +++++++++++++++++
 tb/tb_instr_encoder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Packs symbolic RV32I requests into 32-bit instruction words for the program loader.
// A single output register with valid/ready handshake, plus a wrapping word-address counter.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          DEPTH     = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_class,
  input  logic [4:0]  req_sub,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [31:0] req_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err,
  output logic [15:0] illegal_cnt,
  output logic [15:0] emit_cnt
);

  localparam logic [6:0]  OP_R      = 7'b0110011;
  localparam logic [6:0]  OP_I      = 7'b0010011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OP_LUI    = 7'b0110111;
  localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * (DEPTH - 1));

  logic       alu_ok, alu_shift, br_ok, ld_ok, st_ok;
  logic [2:0] alu_f3, br_f3;
  logic [6:0] alu_f7;
  logic       fits_i, fits_b, fits_j, shamt_ok;
  logic       enc_ok;
  logic [31:0] enc_instr;
  logic       accept, xfer;

  // alu_control numbering: ADD SUB AND OR XOR SLL SRL SRA SLT SLTU (0..9)
  always_comb begin
    alu_ok    = 1'b1;
    alu_shift = 1'b0;
    alu_f3    = 3'b000;
    alu_f7    = 7'b0000000;
    case (req_sub)
      5'd0: alu_f3 = 3'b000;
      5'd1: alu_f7 = 7'b0100000;
      5'd2: alu_f3 = 3'b111;
      5'd3: alu_f3 = 3'b110;
      5'd4: alu_f3 = 3'b100;
      5'd5: begin alu_f3 = 3'b001; alu_shift = 1'b1; end
      5'd6: begin alu_f3 = 3'b101; alu_shift = 1'b1; end
      5'd7: begin alu_f3 = 3'b101; alu_f7 = 7'b0100000; alu_shift = 1'b1; end
      5'd8: alu_f3 = 3'b010;
      5'd9: alu_f3 = 3'b011;
      default: alu_ok = 1'b0;
    endcase
  end

  always_comb begin
    br_ok = 1'b1;
    br_f3 = 3'b000;
    case (req_sub)
      5'd10: br_f3 = 3'b000;
      5'd11: br_f3 = 3'b001;
      5'd12: br_f3 = 3'b100;
      5'd13: br_f3 = 3'b101;
      5'd14: br_f3 = 3'b110;
      5'd15: br_f3 = 3'b111;
      default: br_ok = 1'b0;
    endcase
  end

  // An immediate fits N signed bits when every bit above N-1 equals the sign bit.
  assign fits_i   = (&req_imm[31:11]) | ~(|req_imm[31:11]);
  assign fits_b   = ((&req_imm[31:12]) | ~(|req_imm[31:12])) & ~req_imm[0];
  assign fits_j   = ((&req_imm[31:20]) | ~(|req_imm[31:20])) & ~req_imm[0];
  assign shamt_ok = ~(|req_imm[31:5]);
  assign ld_ok    = (req_sub[2:0] != 3'd3) && (req_sub[2:0] <= 3'd5);
  assign st_ok    = (req_sub[2:0] <= 3'd2);

  always_comb begin
    enc_ok    = 1'b0;
    enc_instr = '0;
    case (req_class)
      4'd0: begin
        enc_ok    = alu_ok;
        enc_instr = {alu_f7, req_rs2, req_rs1, alu_f3, req_rd, OP_R};
      end
      4'd1: begin
        enc_ok    = alu_ok && (req_sub != 5'd1) && (alu_shift ? shamt_ok : fits_i);
        enc_instr = {(alu_shift ? {alu_f7, req_imm[4:0]} : req_imm[11:0]),
                     req_rs1, alu_f3, req_rd, OP_I};
      end
      4'd2: begin
        enc_ok    = ld_ok && fits_i;
        enc_instr = {req_imm[11:0], req_rs1, req_sub[2:0], req_rd, OP_LOAD};
      end
      4'd3: begin
        enc_ok    = st_ok && fits_i;
        enc_instr = {req_imm[11:5], req_rs2, req_rs1, req_sub[2:0], req_imm[4:0], OP_STORE};
      end
      4'd4: begin
        enc_ok    = br_ok && fits_b;
        enc_instr = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, br_f3,
                     req_imm[4:1], req_imm[11], OP_BRANCH};
      end
      4'd5: begin
        enc_ok    = fits_j;
        enc_instr = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, OP_JAL};
      end
      4'd6: begin
        enc_ok    = fits_i;
        enc_instr = {req_imm[11:0], req_rs1, 3'b000, req_rd, OP_JALR};
      end
      4'd7: begin
        enc_ok    = 1'b1;
        enc_instr = {req_imm[19:0], req_rd, OP_AUIPC};
      end
      4'd8: begin
        enc_ok    = 1'b1;
        enc_instr = {req_imm[19:0], req_rd, OP_LUI};
      end
      default: enc_ok = 1'b0;
    endcase
  end

  assign req_ready = !out_valid || out_ready;
  assign accept    = req_valid && req_ready;
  assign xfer      = out_valid && out_ready;

  // out_addr always tracks the slot of the current (or next) word, so it only moves on a transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_instr   <= '0;
      out_addr    <= BASE_ADDR;
      err         <= 1'b0;
      illegal_cnt <= '0;
      emit_cnt    <= '0;
    end else if (clear) begin
      out_valid   <= 1'b0;
      out_addr    <= BASE_ADDR;
      err         <= 1'b0;
      illegal_cnt <= '0;
      emit_cnt    <= '0;
    end else begin
      if (xfer) begin
        out_addr <= (out_addr == LAST_ADDR) ? BASE_ADDR : out_addr + 32'd4;
        if (emit_cnt != 16'hFFFF) emit_cnt <= emit_cnt + 16'd1;
      end
      if (accept && enc_ok) begin
        out_valid <= 1'b1;
        out_instr <= enc_instr;
      end else if (xfer) begin
        out_valid <= 1'b0;
      end
      if (accept && !enc_ok) begin
        err <= 1'b1;
        if (illegal_cnt != 16'hFFFF) illegal_cnt <= illegal_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vectors plus randomized traffic
// scored against a queue-based reference model of the encoder and its output slot.
module tb_instr_encoder;
  localparam logic [31:0] BASE  = 32'h0;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_class = '0;
  logic [4:0]  req_sub = '0, req_rd = '0, req_rs1 = '0, req_rs2 = '0;
  logic [31:0] req_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr, out_addr;
  logic        err;
  logic [15:0] illegal_cnt, emit_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [31:0] instr; logic [31:0] addr; } word_t;
  word_t       q[$];
  logic [31:0] m_addr = BASE;
  logic        m_err = 1'b0;
  logic [15:0] m_ill = '0, m_emit = '0;
  logic [31:0] dir_gold = '0;
  bit          dir_gold_en = 1'b0;

  instr_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_class(req_class), .req_sub(req_sub), .req_rd(req_rd),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .err(err), .illegal_cnt(illegal_cnt), .emit_cnt(emit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference encoder built from field arithmetic on a plain integer immediate.
  function automatic void ref_encode(input int cls, input int sub, input int rd, input int rs1,
                                     input int rs2, input logic [31:0] raw,
                                     output bit legal, output logic [31:0] ins);
    int alu_f3[10] = '{0, 0, 7, 6, 4, 1, 5, 5, 2, 3};
    int alu_f7[10] = '{0, 32, 0, 0, 0, 0, 0, 32, 0, 0};
    int br_f3[6]   = '{0, 1, 4, 5, 6, 7};
    int v  = int'(signed'(raw));
    int f3 = sub % 8;
    bit i_rng = (v >= -2048) && (v <= 2047);
    legal = 1'b1;
    ins   = '0;
    case (cls)
      0: if (sub <= 9) ins = (alu_f7[sub] << 25) | (rs2 << 20) | (rs1 << 15) | (alu_f3[sub] << 12) | (rd << 7) | 'h33;
         else legal = 1'b0;
      1: if (sub > 9 || sub == 1) legal = 1'b0;
         else if (sub >= 5 && sub <= 7) begin
           if (v < 0 || v > 31) legal = 1'b0;
           else ins = (alu_f7[sub] << 25) | (v << 20) | (rs1 << 15) | (alu_f3[sub] << 12) | (rd << 7) | 'h13;
         end else if (!i_rng) legal = 1'b0;
         else ins = ((v & 'hFFF) << 20) | (rs1 << 15) | (alu_f3[sub] << 12) | (rd << 7) | 'h13;
      2: if (!(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) || !i_rng) legal = 1'b0;
         else ins = ((v & 'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h03;
      3: if (f3 > 2 || !i_rng) legal = 1'b0;
         else ins = (((v >> 5) & 'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | ((v & 31) << 7) | 'h23;
      4: if (sub < 10 || sub > 15 || v < -4096 || v > 4094 || (v & 1) != 0) legal = 1'b0;
         else ins = (((v >> 12) & 1) << 31) | (((v >> 5) & 63) << 25) | (rs2 << 20) | (rs1 << 15)
                  | (br_f3[sub-10] << 12) | (((v >> 1) & 15) << 8) | (((v >> 11) & 1) << 7) | 'h63;
      5: if (v < -(1 << 20) || v > (1 << 20) - 2 || (v & 1) != 0) legal = 1'b0;
         else ins = (((v >> 20) & 1) << 31) | (((v >> 1) & 'h3FF) << 21) | (((v >> 11) & 1) << 20)
                  | (((v >> 12) & 'hFF) << 12) | (rd << 7) | 'h6F;
      6: if (!i_rng) legal = 1'b0;
         else ins = ((v & 'hFFF) << 20) | (rs1 << 15) | (rd << 7) | 'h67;
      7: ins = ((raw & 32'hFFFFF) << 12) | (rd << 7) | 'h17;
      8: ins = ((raw & 32'hFFFFF) << 12) | (rd << 7) | 'h37;
      default: legal = 1'b0;
    endcase
  endfunction

  // Scoreboard: observes settled state mid-cycle, then predicts the coming edge.
  always @(negedge clk) begin
    bit          lg;
    logic [31:0] ins;
    bit          exp_ready;
    word_t       w;
    if (rst) begin
      q.delete();
      m_addr = BASE; m_err = 1'b0; m_ill = '0; m_emit = '0;
    end else begin
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        chk("out_instr", out_instr, q[0].instr);
        chk("out_addr", out_addr, q[0].addr);
      end
      exp_ready = (q.size() == 0) || out_ready;
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("err", 32'(err), 32'(m_err));
      chk("illegal_cnt", 32'(illegal_cnt), 32'(m_ill));
      chk("emit_cnt", 32'(emit_cnt), 32'(m_emit));
      if (clear) begin
        q.delete();
        m_addr = BASE; m_err = 1'b0; m_ill = '0; m_emit = '0;
      end else begin
        if (q.size() != 0 && out_ready) begin
          void'(q.pop_front());
          if (m_emit != 16'hFFFF) m_emit++;
        end
        if (req_valid && exp_ready) begin
          ref_encode(int'(req_class), int'(req_sub), int'(req_rd), int'(req_rs1), int'(req_rs2),
                     req_imm, lg, ins);
          if (lg) begin
            w.instr = dir_gold_en ? dir_gold : ins;
            w.addr  = m_addr;
            q.push_back(w);
            m_addr = (m_addr == BASE + 32'(4 * (DEPTH - 1))) ? BASE : m_addr + 32'd4;
          end else begin
            m_err = 1'b1;
            if (m_ill != 16'hFFFF) m_ill++;
          end
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the request was taken.
  task automatic send(input int cls, input int sub, input int rd, input int rs1, input int rs2,
                      input logic [31:0] imm, input logic [31:0] gold, input bit use_gold);
    int n = 0;
    req_class = 4'(cls); req_sub = 5'(sub); req_rd = 5'(rd);
    req_rs1 = 5'(rs1); req_rs2 = 5'(rs2); req_imm = imm;
    dir_gold = gold; dir_gold_en = use_gold;
    req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("accept_timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0; dir_gold_en = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  function automatic logic [31:0] pick_imm();
    int sel = $urandom_range(0, 19);
    case (sel)
      0: return -32'sd4097;   1: return -32'sd4096;  2: return -32'sd2049;  3: return -32'sd2048;
      4: return 32'hFFFFFFFF; 5: return 32'd0;       6: return 32'd1;       7: return 32'd3;
      8: return 32'd31;       9: return 32'd32;     10: return 32'd2047;   11: return 32'd2048;
      12: return 32'd4094;   13: return 32'd4095;   14: return 32'd1048574; 15: return 32'd1048576;
      16: return 32'hFFF00000; 17: return 32'($urandom_range(0, 4095)) & 32'hFFE;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_addr", out_addr, BASE);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_illegal_cnt", 32'(illegal_cnt), 32'd0);
    chk("rst_emit_cnt", 32'(emit_cnt), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    cycles(1);

    // Directed encodings, back-to-back
    send(0, 0, 3, 1, 2, 32'd0, 32'h002081B3, 1);
    send(0, 1, 3, 1, 2, 32'd0, 32'h402081B3, 1);
    send(1, 0, 1, 0, 0, 32'd5, 32'h00500093, 1);
    send(1, 7, 1, 1, 0, 32'd3, 32'h4030D093, 1);
    send(3, 2, 0, 1, 2, 32'd8, 32'h0020A423, 1);
    send(4, 10, 0, 1, 2, 32'd8, 32'h00208463, 1);
    send(5, 0, 1, 0, 0, 32'd16, 32'h010000EF, 1);
    send(8, 0, 5, 0, 0, 32'h12345, 32'h123452B7, 1);
    cycles(3);

    // Illegal requests: nothing emitted, address frozen
    do_clear();
    send(1, 0, 1, 0, 0, 32'd2048, 32'h0, 0);
    send(4, 10, 0, 1, 2, 32'd3, 32'h0, 0);
    send(0, 10, 3, 1, 2, 32'd0, 32'h0, 0);
    cycles(2);
    chk("illegal_out_valid", 32'(out_valid), 32'd0);
    chk("illegal_addr", out_addr, BASE);
    chk("illegal_err", 32'(err), 32'd1);
    chk("illegal_cnt_3", 32'(illegal_cnt), 32'd3);

    // Backpressure: sink stalls 5 cycles while 3 requests are offered
    do_clear();
    fork
      begin
        send(1, 0, 1, 0, 0, 32'd1, 32'h00100093, 1);
        send(1, 0, 2, 0, 0, 32'd2, 32'h00200113, 1);
        send(1, 0, 3, 0, 0, 32'd3, 32'h00300193, 1);
      end
      begin
        out_ready = 1'b0;
        cycles(5);
        out_ready = 1'b1;
      end
    join
    cycles(4);
    chk("bp_emit_cnt", 32'(emit_cnt), 32'd3);

    // Address wrap at DEPTH words
    do_clear();
    chk("clear_addr", out_addr, BASE);
    for (int i = 0; i < 5; i++) send(8, 0, i + 1, 0, 0, 32'(i), 32'h0, 0);
    cycles(3);
    chk("wrap_addr_after5", out_addr, BASE + 32'd4);

    // clear with a pending word, a transfer and a new request in the same cycle
    send(1, 0, 1, 0, 0, 32'd4096, 32'h0, 0);
    out_ready = 1'b0;
    send(1, 0, 1, 0, 0, 32'd7, 32'h00700093, 1);
    req_class = 4'd8; req_sub = '0; req_rd = 5'd9; req_imm = 32'hABCDE;
    req_valid = 1'b1; out_ready = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; clear = 1'b0;
    chk("clr_out_valid", 32'(out_valid), 32'd0);
    chk("clr_addr", out_addr, BASE);
    chk("clr_emit", 32'(emit_cnt), 32'd0);
    chk("clr_illegal", 32'(illegal_cnt), 32'd0);
    chk("clr_err", 32'(err), 32'd0);
    cycles(2);

    // Asynchronous reset with a held word
    out_ready = 1'b0;
    send(7, 0, 4, 0, 0, 32'h00042, 32'h00042217, 1);
    #3 rst = 1'b1;
    #4;
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_out_instr", out_instr, 32'd0);
    chk("mrst_out_addr", out_addr, BASE);
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    cycles(2);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_class = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      req_sub   = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 15));
      req_rd    = 5'($urandom); req_rs1 = 5'($urandom); req_rs2 = 5'($urandom);
      req_imm   = pick_imm();
      out_ready = ($urandom_range(0, 3) != 0);
      clear     = ($urandom_range(0, 99) == 0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0; clear = 1'b0; out_ready = 1'b1;
    cycles(4);
    chk("drain_out_valid", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
